// File: rtl/load_sequencer.sv
// load_sequencer: multi-cycle load unit. It decodes a load instruction,
// issues one aligned memory read, waits for the acknowledge with a timeout,
// then extracts and extends the addressed lane for the register-file write.
// Build option: define LOAD_MISALIGN_TRAP_EN to fault on misaligned addresses
// instead of silently aligning them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; decode, effective address, legality
// S_REQ   | mem_req held high, address stable, waiting for mem_ack
// S_WB    | one-cycle completion: done, rd_data valid, rd_we unless x0
// S_FAULT | one-cycle abort: done and fault with fault_cause

module load_sequencer #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [31:0]     INSN,
   input  logic            start,
   input  logic [XLEN-1:0] rs1_val,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_req,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_we,
   output logic            busy,
   output logic            done,
   output logic            fault,
   output logic [1:0]      fault_cause
);

   localparam int LANE_W = $clog2(XLEN / 8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WB,
      S_FAULT
   } state_t;

   state_t            state;
   logic [7:0]        wait_cnt;
   logic [2:0]        funct3_q;
   logic [LANE_W-1:0] lane_q;

   logic [2:0]        funct3;
   logic [XLEN-1:0]   ea;
   logic [XLEN-1:0]   ea_nat;
   logic [2:0]        size_mask;
   logic              legal;
   logic              misaligned;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_val;

   // The rs1 field is not needed here: the base value arrives on rs1_val.
   logic              unused_insn;
   assign unused_insn = ^INSN[19:15];

   assign funct3 = INSN[14:12];

   // Decode of the incoming instruction: effective address, natural
   // alignment of the access size, and legality for this XLEN.
   always_comb begin
      ea = rs1_val + XLEN'($signed(INSN[31:20]));
      case (funct3[1:0])
         2'b00:   size_mask = 3'b000;
         2'b01:   size_mask = 3'b001;
         2'b10:   size_mask = 3'b011;
         default: size_mask = 3'b111;
      endcase
      ea_nat = ea & ~XLEN'(size_mask);

      legal = 1'b0;
      if (INSN[6:0] == 7'b0000011) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110:                         legal = (XLEN == 64);
            default:                                legal = 1'b0;
         endcase
      end

`ifdef LOAD_MISALIGN_TRAP_EN
      misaligned = |(ea[2:0] & size_mask);
`else
      misaligned = 1'b0;
`endif
   end

   // Lane select and extension of the returned word, driven straight from
   // mem_rdata so the result is registered in the acknowledge cycle.
   always_comb begin
      shifted = mem_rdata >> {lane_q, 3'b000};
      case (funct3_q)
         3'b000:  load_val = XLEN'($signed(shifted[7:0]));
         3'b001:  load_val = XLEN'($signed(shifted[15:0]));
         3'b010:  load_val = XLEN'($signed(shifted[31:0]));
         3'b100:  load_val = XLEN'(shifted[7:0]);
         3'b101:  load_val = XLEN'(shifted[15:0]);
         3'b110:  load_val = XLEN'(shifted[31:0]);
         default: load_val = shifted;
      endcase
   end

   // Sequencer FSM with all outputs registered; done/fault/rd_we are pulses
   // that default low every cycle and are raised only on WB/FAULT entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         wait_cnt    <= 8'd0;
         funct3_q    <= 3'b000;
         lane_q      <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         rd_addr     <= 5'd0;
         rd_data     <= '0;
         rd_we       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         done        <= 1'b0;
         fault       <= 1'b0;
         rd_we       <= 1'b0;
         fault_cause <= 2'b00;
         case (state)
            S_IDLE: begin
               if (start) begin
                  funct3_q <= funct3;
                  lane_q   <= ea_nat[LANE_W-1:0];
                  rd_addr  <= INSN[11:7];
                  mem_addr <= {ea_nat[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                  wait_cnt <= 8'd0;
                  busy     <= 1'b1;
                  if (!legal) begin
                     state       <= S_FAULT;
                     done        <= 1'b1;
                     fault       <= 1'b1;
                     fault_cause <= 2'b01;
                  end else if (misaligned) begin
                     state       <= S_FAULT;
                     done        <= 1'b1;
                     fault       <= 1'b1;
                     fault_cause <= 2'b10;
                  end else begin
                     state   <= S_REQ;
                     mem_req <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  state   <= S_WB;
                  mem_req <= 1'b0;
                  rd_data <= load_val;
                  done    <= 1'b1;
                  rd_we   <= (rd_addr != 5'd0);
               end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                  state       <= S_FAULT;
                  mem_req     <= 1'b0;
                  done        <= 1'b1;
                  fault       <= 1'b1;
                  fault_cause <= 2'b11;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB, S_FAULT: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
// Scoreboard bench for load_sequencer (XLEN=32, MAX_WAIT=4). Each issued
// load pushes its expected completion and expected address; monitors pop and
// compare when the DUT shows done or raises mem_req.

module tb_load_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] INSN = '0;
   logic        start = 1'b0;
   logic [31:0] rs1_val = '0;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_we;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  fault_cause;

   load_sequencer #(.XLEN(32), .MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST), .INSN(INSN), .start(start), .rs1_val(rs1_val),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_we(rd_we), .busy(busy), .done(done), .fault(fault),
      .fault_cause(fault_cause)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        flt;
      logic [1:0]  cause;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int ack_wait = 0;
   int req_cnt  = 0;
   int reqs_seen = 0;
   bit force_ack = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic f, input logic [1:0] c, input logic we,
                               input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.flt = f; e.cause = c; e.we = we; e.rd = rd; e.data = d;
      return e;
   endfunction

   // Memory model: acknowledges after ack_wait REQ cycles; optional idle ack.
   always @(negedge CLK) begin
      if (mem_req) begin
         mem_ack = (req_cnt == ack_wait);
         req_cnt++;
         reqs_seen++;
      end else begin
         mem_ack = force_ack;
         req_cnt = 0;
      end
   end

   // Completion monitor.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
               e = exp_q.pop_front();
               chk("fault", 32'(fault), 32'(e.flt));
               chk("fault_cause", 32'(fault_cause), 32'(e.cause));
               chk("rd_we", 32'(rd_we), 32'(e.we));
               if (!e.flt) begin
                  chk("rd_addr", 32'(rd_addr), 32'(e.rd));
                  chk("rd_data", rd_data, e.data);
               end
            end
         end else if (rd_we) begin
            n_checks++; n_fail++;
            $display("FAIL stray_rd_we: got rd_we=1 with done=0 expected 0");
         end
      end
   end

   // Address monitor: expected address popped when mem_req rises, then held.
   logic        prev_req = 1'b0;
   logic [31:0] cur_addr = '0;
   always @(negedge CLK) begin
      if (mem_req) begin
         if (!prev_req) begin
            if (addr_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_req: got mem_req=1 expected 0");
            end else begin
               cur_addr = addr_q.pop_front();
            end
         end
         chk("mem_addr", mem_addr, cur_addr);
      end
      prev_req = mem_req;
   end

   task automatic issue(input string nm, input logic [31:0] insn, input logic [31:0] rs1,
                        input logic [31:0] rdata, input int aw, input exp_t e,
                        input bit has_addr, input logic [31:0] addr,
                        input int exp_lat, input int exp_reqs, input bit spurious);
      bit seen = 1'b0;
      int lat = 0;
      @(negedge CLK);
      INSN = insn; rs1_val = rs1; mem_rdata = rdata; ack_wait = aw; reqs_seen = 0;
      exp_q.push_back(e);
      if (has_addr) addr_q.push_back(addr);
      start = 1'b1;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge CLK);
         if (k == 1 && spurious) begin
            start = 1'b1;
            INSN  = 32'h0000_0013;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      start = 1'b0;
      if (!seen) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
      end else begin
         chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
         chk({nm, "_mem_req_cycles"}, 32'(reqs_seen), 32'(exp_reqs));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rd_we", 32'(rd_we), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_fault_cause", 32'(fault_cause), 0);
      RST = 1'b0;

      issue("lw", 32'h0087A803, 32'h1000, 32'hDEADBEEF, 0,
            mk(0, 2'b00, 1, 5'd16, 32'hDEADBEEF), 1, 32'h1008, 2, 1, 0);
      issue("lb", 32'h00378803, 32'h1000, 32'h80FFFFFF, 0,
            mk(0, 2'b00, 1, 5'd16, 32'hFFFFFF80), 1, 32'h1000, 2, 1, 0);
      issue("lbu", 32'h0037C803, 32'h1000, 32'h80FFFFFF, 0,
            mk(0, 2'b00, 1, 5'd16, 32'h00000080), 1, 32'h1000, 2, 1, 0);
      issue("lh_wait", 32'h00209283, 32'h2000, 32'h80011234, 2,
            mk(0, 2'b00, 1, 5'd5, 32'hFFFF8001), 1, 32'h2000, 4, 3, 1);
      issue("lhu", 32'h0020D283, 32'h2000, 32'h80011234, 0,
            mk(0, 2'b00, 1, 5'd5, 32'h00008001), 1, 32'h2000, 2, 1, 0);
      issue("lw_neg", 32'hFFC0A383, 32'h3000, 32'h12345678, 0,
            mk(0, 2'b00, 1, 5'd7, 32'h12345678), 1, 32'h2FFC, 2, 1, 0);
      issue("lb_lane1", 32'h00108483, 32'h4000, 32'h11227F44, 0,
            mk(0, 2'b00, 1, 5'd9, 32'h0000007F), 1, 32'h4000, 2, 1, 0);
      issue("timeout", 32'h0087A803, 32'h1000, 32'h0, 1000,
            mk(1, 2'b11, 0, 5'd0, 32'h0), 1, 32'h1008, 5, 4, 0);
      issue("illegal_op", 32'h00000013, 32'h1000, 32'h0, 0,
            mk(1, 2'b01, 0, 5'd0, 32'h0), 0, 32'h0, 1, 0, 0);
      issue("illegal_ld32", 32'h0000B003, 32'h1000, 32'h0, 0,
            mk(1, 2'b01, 0, 5'd0, 32'h0), 0, 32'h0, 1, 0, 0);
`ifdef LOAD_MISALIGN_TRAP_EN
      issue("mis_lw", 32'h0087A803, 32'h1001, 32'hCAFEF00D, 0,
            mk(1, 2'b10, 0, 5'd0, 32'h0), 0, 32'h0, 1, 0, 0);
      issue("mis_lh", 32'h00209283, 32'h2001, 32'h9ABC0000, 0,
            mk(1, 2'b10, 0, 5'd0, 32'h0), 0, 32'h0, 1, 0, 0);
`else
      issue("mis_lw", 32'h0087A803, 32'h1001, 32'hCAFEF00D, 0,
            mk(0, 2'b00, 1, 5'd16, 32'hCAFEF00D), 1, 32'h1008, 2, 1, 0);
      issue("mis_lh", 32'h00209283, 32'h2001, 32'h9ABC0000, 0,
            mk(0, 2'b00, 1, 5'd5, 32'hFFFF9ABC), 1, 32'h2000, 2, 1, 0);
`endif

      // Acknowledge while idle must not start or complete anything.
      @(negedge CLK);
      force_ack = 1'b1;
      repeat (3) @(negedge CLK);
      chk("idle_ack_busy", 32'(busy), 0);
      force_ack = 1'b0;

      // Reset in the middle of a request aborts silently.
      @(negedge CLK);
      INSN = 32'h0087A803; rs1_val = 32'h1000; ack_wait = 1000;
      addr_q.push_back(32'h1008);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("pre_rst_mem_req", 32'(mem_req), 1);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst_mem_req", 32'(mem_req), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_rd_we", 32'(rd_we), 0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);

      issue("rd_x0", 32'h0087A003, 32'h1000, 32'h55AA55AA, 0,
            mk(0, 2'b00, 0, 5'd0, 32'h55AA55AA), 1, 32'h1008, 2, 1, 0);

      repeat (3) @(negedge CLK);
      n_checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0",
                  exp_q.size(), addr_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
